// File: rtl/muldiv_pkg.sv
// Shared types and defaults for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit, one result bit per clock, results held in HI/LO.
// Optional macro MULDIV_ZERO_SKIP_EN: bypass CALC when either operand is zero.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CW = $clog2(XLEN);

    state_e          state;
    state_e          state_nxt;
    op_e             op_q;
    op_e             op_in;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic            neg_q;
    logic            neg_r;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;

    logic            signed_in;
    logic            rs_neg_in;
    logic            rt_neg_in;
    logic [XLEN-1:0] rs_abs;
    logic [XLEN-1:0] rt_abs;
    logic            is_div;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_trial;
    logic [2*XLEN-1:0] prod_mag;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   dvz_hi;

    assign op_in     = op_e'(op);
    assign signed_in = (op_in == OP_MULT) || (op_in == OP_DIV);
    assign rs_neg_in = signed_in & rs_val[XLEN-1];
    assign rt_neg_in = signed_in & rt_val[XLEN-1];
    assign rs_abs    = rs_neg_in ? -rs_val : rs_val;
    assign rt_abs    = rt_neg_in ? -rt_val : rt_val;
    assign is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);

    // Single iteration of shift-add multiply and restoring divide on magnitudes.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_q} : '0);
    assign div_shift = {acc_hi, acc_lo[XLEN-1]};
    assign div_trial = div_shift - {1'b0, b_q};

    assign prod_mag = {acc_hi, acc_lo};
    assign prod_fix = neg_q ? -prod_mag : prod_mag;
    assign quo_fix  = neg_q ? -acc_lo : acc_lo;
    assign rem_fix  = neg_r ? -acc_hi : acc_hi;
    // Restores the original dividend bit pattern from its magnitude.
    assign dvz_hi   = neg_r ? -a_q : a_q;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef MULDIV_ZERO_SKIP_EN
                    state_nxt = ((rs_val == '0) || (rt_val == '0)) ? FIX : CALC;
`else
                    state_nxt = CALC;
`endif
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    state_nxt = FIX;
                end
            end
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and the sign-corrected write of HI/LO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q   <= OP_MULT;
            a_q    <= '0;
            b_q    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q   <= op_in;
                        a_q    <= rs_abs;
                        b_q    <= rt_abs;
                        neg_q  <= rs_neg_in ^ rt_neg_in;
                        neg_r  <= rs_neg_in;
                        cnt    <= CW'(XLEN - 1);
                        acc_hi <= '0;
                        acc_lo <= rs_abs;
                    end
                end
                CALC: begin
                    cnt <= cnt - CW'(1);
                    if (is_div) begin
                        if (!div_trial[XLEN]) begin
                            acc_hi <= div_trial[XLEN-1:0];
                            acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
                        end else begin
                            acc_hi <= div_shift[XLEN-1:0];
                            acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        acc_hi <= mul_sum[XLEN:1];
                        acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
                    end
                end
                FIX: begin
                    // Zero operands are resolved here so the skip path needs no CALC results.
                    if (is_div) begin
                        if (b_q == '0) begin
                            hi <= dvz_hi;
                            lo <= '1;
                        end else if (a_q == '0) begin
                            hi <= '0;
                            lo <= '0;
                        end else begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end
                    end else begin
                        if ((a_q == '0) || (b_q == '0)) begin
                            hi <= '0;
                            lo <= '0;
                        end else begin
                            hi <= prod_fix[2*XLEN-1:XLEN];
                            lo <= prod_fix[XLEN-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: random and directed operations against an arithmetic model.
module tb_muldiv_unit;

    localparam int XLEN = 32;

    typedef struct {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
        int              e0;
        int              lat;
    } exp_t;

    logic            clk;
    logic            reset;
    logic            start;
    logic [1:0]      op_sel;
    logic [XLEN-1:0] rs_v;
    logic [XLEN-1:0] rt_v;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    exp_t sb[$];
    exp_t mon_e;
    int   tests;
    int   fails;
    int   edges;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op_sel),
        .rs_val (rs_v),
        .rt_val (rt_v),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: plain integer arithmetic, result packed as {hi, lo}.
    function automatic logic [2*XLEN-1:0] model(input logic [1:0] o, input logic [XLEN-1:0] rs,
                                                input logic [XLEN-1:0] rt);
        int     sa;
        int     sb_;
        longint p;
        logic [2*XLEN-1:0] r;
        sa  = rs;
        sb_ = rt;
        case (o)
            2'b00: begin
                p = longint'(sa) * longint'(sb_);
                r = p;
            end
            2'b01: r = {32'h0, rs} * {32'h0, rt};
            2'b10: begin
                if (rt == 0)                                  r = {rs, 32'hFFFF_FFFF};
                else if (rs == 32'h8000_0000 && rt == '1)     r = {32'h0, 32'h8000_0000};
                else                                          r = {32'(sa % sb_), 32'(sa / sb_)};
            end
            default: begin
                if (rt == 0) r = {rs, 32'hFFFF_FFFF};
                else         r = {rs % rt, rs / rt};
            end
        endcase
        return r;
    endfunction

    // Edges from the accepting edge until done is visible.
    function automatic int exp_lat(input logic [XLEN-1:0] rs, input logic [XLEN-1:0] rt);
`ifdef MULDIV_ZERO_SKIP_EN
        if (rs == 0 || rt == 0) return 1;
`endif
        return XLEN + 1;
    endfunction

    task automatic checkOutput(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] o, input logic [XLEN-1:0] rs, input logic [XLEN-1:0] rt);
        exp_t             e;
        logic [2*XLEN-1:0] m;
        @(negedge clk);
        start  = 1'b1;
        op_sel = o;
        rs_v   = rs;
        rt_v   = rt;
        m      = model(o, rs, rt);
        e.hi   = m[2*XLEN-1:XLEN];
        e.lo   = m[XLEN-1:0];
        e.e0   = edges + 1;
        e.lat  = exp_lat(rs, rt);
        sb.push_back(e);
        @(negedge clk);
        start  = 1'b0;
        op_sel = 2'($urandom);
        rs_v   = $urandom;
        rt_v   = $urandom;
        checkOutput("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic waitDone(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s_timeout: %0d results pending after %0d cycles, required 0", name, sb.size(), n);
            sb.delete();
        end
    endtask

    function automatic logic [XLEN-1:0] pick_operand();
        case ($urandom_range(0, 9))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return '1;
            3:       return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        tests  = 0;
        fails  = 0;
        edges  = 0;
        reset  = 1'b1;
        start  = 1'b0;
        op_sel = 2'b00;
        rs_v   = '0;
        rt_v   = '0;

        fork
            forever begin
                @(negedge clk);
                if (!reset && done) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL spurious_done: done=1 with nothing pending at edge %0d, required done=0", edges);
                    end else begin
                        mon_e = sb.pop_front();
                        checkOutput("hi", hi, mon_e.hi);
                        checkOutput("lo", lo, mon_e.lo);
                        checkOutput("latency", 32'(edges - mon_e.e0), 32'(mon_e.lat));
                        checkOutput("busy_at_done", 32'(busy), 32'd1);
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_hi", hi, '0);
        checkOutput("reset_lo", lo, '0);
        @(negedge clk);
        reset = 1'b0;

        // Directed corner cases.
        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF); waitDone("multu_max");
        applyStimulus(2'b00, 32'hFFFF_FFFD, 32'd7);         waitDone("mult_neg");
        applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2);         waitDone("div_neg");
        applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF); waitDone("div_ovf");
        applyStimulus(2'b11, 32'd100, 32'd0);               waitDone("divu_zero");
        applyStimulus(2'b10, 32'hFFFF_FF00, 32'd0);         waitDone("div_zero_neg");
        applyStimulus(2'b10, 32'd0, 32'd5);                 waitDone("div_zero_dividend");
        applyStimulus(2'b00, 32'd0, 32'hFFFF_FFFF);         waitDone("mult_zero");

        // A second start while busy must be dropped without a second done.
        applyStimulus(2'b01, 32'd3, 32'd5);
        repeat (4) @(negedge clk);
        start  = 1'b1;
        op_sel = 2'b11;
        rs_v   = 32'd9;
        rt_v   = 32'd3;
        @(negedge clk);
        start = 1'b0;
        waitDone("ignored_start");
        repeat (XLEN + 6) @(negedge clk);

        // Reset mid-operation discards the in-flight divide.
        applyStimulus(2'b11, 32'd50, 32'd7);
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        sb.delete();
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_done", 32'(done), 32'd0);
        checkOutput("midreset_hi", hi, '0);
        checkOutput("midreset_lo", lo, '0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(2'b01, 32'd6, 32'd7);                 waitDone("after_reset");

        for (int i = 0; i < 40; i++) begin
            applyStimulus(2'($urandom), pick_operand(), pick_operand());
            waitDone("random");
        end

        repeat (4) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
